// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures two WIDTH-bit operands plus carry-in,
// adds them one bit per clock LSB first, and presents a registered {cout,sum}.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_x;
    logic             w_y;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_sh_next;

    assign w_x           = r_a_sh[0];
    assign w_y           = r_b_sh[0];
    assign w_s           = w_x ^ w_y ^ r_carry;
    assign w_c           = (w_x & w_y) | ((w_x ^ w_y) & r_carry);
    assign w_last        = (r_cnt == CW'(WIDTH - 1));
    assign w_sum_sh_next = {w_s, r_sum_sh[WIDTH-1:1]};

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_carry  <= cin;
                        r_sum_sh <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_sum_sh <= w_sum_sh_next;
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry  <= w_c;
                    r_cnt    <= r_cnt + CW'(1);
                    // Only the final bit publishes; partial sums stay internal.
                    if (w_last) begin
                        r_sum  <= w_sum_sh_next;
                        r_cout <= w_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: the driver pushes a+b+cin per accepted
// start, a negedge monitor pops and compares on every done pulse.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int           n_checks;
    int           n_errors;
    logic [W:0]   exp_q[$];
    logic [W:0]   prev_res;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares results on done, and checks outputs are stable otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_res = '0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {cout, sum}, 64'hdead);
            end else begin
                check("result", {cout, sum}, exp_q.pop_front());
            end
            prev_res = {cout, sum};
        end else begin
            check("result_hold", {cout, sum}, prev_res);
        end
    end

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input bit noisy);
        int busy_cnt;
        int done_cnt;
        int done_at;
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        exp_q.push_back({1'b0, av} + {1'b0, bv} + (W+1)'(cv));
        @(posedge clk);
        #1;
        check("busy_after_accept", busy, 1'b1);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (noisy) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        check("busy_cycles", busy_cnt, W);
        check("done_count", done_cnt, 1);
        check("done_latency", done_at, W + 1);
        @(negedge clk);
        check("idle_after_done", {busy, done}, 2'b00);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        prev_res = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        #1;
        check("reset_outputs", {busy, done, cout, sum}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'h5A, 8'h3C, 1'b1, 1'b0);
        check("dir_5a_3c", {cout, sum}, 9'h097);
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        check("dir_ff_01", {cout, sum}, 9'h100);
        issue(8'hFF, 8'hFF, 1'b1, 1'b0);
        check("dir_ff_ff_c", {cout, sum}, 9'h1FF);

        // start held high with operands scrambled during RUN
        for (int i = 0; i < 4; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end
        start = 1'b0;

        // Abort after 4 RUN edges: no entry is queued, so any done is flagged.
        a     = 8'hC3;
        b     = 8'h7E;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {busy, done, cout, sum}, '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_outputs", {busy, done, cout, sum}, '0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'h01, 8'h02, 1'b0, 1'b0);
        check("post_reset_sum", {cout, sum}, 9'h003);

        // back-to-back random campaign
        for (int i = 0; i < 1000; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
